ahb_sram_slave: RTL and testbench

//  AHB-Lite slave with single-port register-file memory; downstream consumer of AHB_write_master in the

---
 rtl/ahb_sram_slave.sv | 205 ++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a single-port register-file memory.
// Accepts byte/half/word reads and writes. Out-of-window, misaligned and
// unsupported-size transfers get a two-cycle ERROR response.
// wr_count reports committed write beats and saturates at 16'hFFFF.
// Optional feature macro: AHB_SLAVE_WAIT_EN inserts WAIT_CYCLES wait states
// before every OKAY data phase.
// DATAWIDTH must stay 32 because the memory is organised as four byte lanes.
module ahb_sram_slave #(
  parameter int          ADDRESSWIDTH  = 32,
  parameter int          DATAWIDTH     = 32,
  parameter int          MEM_DEPTH     = 256,
  parameter int          MEM_DEPTH_LOG = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter int          WAIT_CYCLES   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    HSEL,
  input  logic [ADDRESSWIDTH-1:0] HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic [DATAWIDTH-1:0]    HWDATA,
  input  logic                    HREADYIN,
  output logic                    HREADY,
  output logic [1:0]              HRESP,
  output logic [DATAWIDTH-1:0]    HRDATA,
  output logic [15:0]             wr_count
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Window limits are kept one bit wider than HADDR so the compare cannot wrap.
  localparam logic [ADDRESSWIDTH-1:0] BASE_A = ADDRESSWIDTH'(BASE_ADDR);
  localparam logic [ADDRESSWIDTH:0]   WINDOW = (ADDRESSWIDTH+1)'(4 * MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2,
    ST_WAIT
  } state_t;

  state_t                   state_reg;
  logic                     hready_reg;
  logic [1:0]               hresp_reg;
  logic [15:0]              wr_count_reg;
  logic [MEM_DEPTH_LOG-1:0] idx_reg;
  logic [1:0]               lane_reg;
  logic [2:0]               size_reg;
  logic                     write_reg;

  logic                     accept;
  logic [ADDRESSWIDTH-1:0]  offset;
  logic                     in_range;
  logic                     misaligned;
  logic                     bad_size;
  logic                     xfer_err;
  logic [3:0]               lane_en;
  logic                     commit;
  logic [DATAWIDTH-1:0]     rd_word;

`ifdef AHB_SLAVE_WAIT_EN
  // A zero or oversized setting is clamped into the 1..7 range of the counter.
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES < 1) ? 3'd1 :
                                     (WAIT_CYCLES > 7) ? 3'd7 : 3'(WAIT_CYCLES);
  logic [2:0] wait_cnt_reg;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  // Burst type, protection and the BUSY/SEQ distinction do not affect this slave.
  logic unused_ok;
  assign unused_ok = &{1'b0, HBURST, HPROT, HTRANS[0]};

  // A new address phase is taken only while this slave is not stalling the bus.
  assign accept   = HSEL & HREADYIN & HTRANS[1] & hready_reg;
  assign offset   = HADDR - BASE_A;
  assign in_range = ({1'b0, HADDR} >= {1'b0, BASE_A}) && ({1'b0, offset} < WINDOW);
  assign bad_size = (HSIZE > 3'b010);
  assign xfer_err = bad_size | misaligned | ~in_range;

  // Alignment rule depends on the transfer size; bytes are always aligned.
  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      3'b001:  misaligned = HADDR[0];
      3'b010:  misaligned = |HADDR[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Little-endian byte-lane enables for the transfer in its data phase.
  always_comb begin
    lane_en = 4'b0000;
    case (size_reg)
      3'b000:  lane_en = 4'b0001 << lane_reg;
      3'b001:  lane_en = lane_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // A reset edge that lands on the data phase aborts the write.
  assign commit = (state_reg == ST_DATA) & write_reg & reset_n;

  // One byte-wide array per lane keeps each lane's write port independent.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];

      // Store this lane's byte when the committing write enables it.
      always_ff @(posedge clk) begin
        if (commit && lane_en[gi]) begin
          lane_mem[idx_reg] <= HWDATA[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[idx_reg];
    end
  endgenerate

  // Read data is only presented in a read data phase; the bus sees zero otherwise.
  assign HRDATA   = ((state_reg == ST_DATA) && !write_reg) ? rd_word : '0;
  assign HREADY   = hready_reg;
  assign HRESP    = hresp_reg;
  assign wr_count = wr_count_reg;

  // Transfer FSM: address capture, error sequencing and optional wait states.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      hready_reg <= 1'b1;
      hresp_reg  <= RESP_OKAY;
      idx_reg    <= '0;
      lane_reg   <= '0;
      size_reg   <= '0;
      write_reg  <= 1'b0;
`ifdef AHB_SLAVE_WAIT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_ERR1: begin
          // Second error cycle releases the bus while still signalling ERROR.
          state_reg  <= ST_ERR2;
          hready_reg <= 1'b1;
          hresp_reg  <= RESP_ERROR;
        end
`ifdef AHB_SLAVE_WAIT_EN
        ST_WAIT: begin
          if (wait_cnt_reg == 3'd1) begin
            state_reg  <= ST_DATA;
            hready_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end
`endif
        default: begin
          // IDLE, DATA and ERR2 all leave HREADY high, so a pipelined address
          // phase can be taken here.
          if (accept) begin
            idx_reg   <= offset[MEM_DEPTH_LOG+1:2];
            lane_reg  <= HADDR[1:0];
            size_reg  <= HSIZE;
            write_reg <= HWRITE;
            if (xfer_err) begin
              state_reg  <= ST_ERR1;
              hready_reg <= 1'b0;
              hresp_reg  <= RESP_ERROR;
            end else begin
              hresp_reg <= RESP_OKAY;
`ifdef AHB_SLAVE_WAIT_EN
              state_reg    <= ST_WAIT;
              hready_reg   <= 1'b0;
              wait_cnt_reg <= WAIT_LOAD;
`else
              state_reg  <= ST_DATA;
              hready_reg <= 1'b1;
`endif
            end
          end else begin
            state_reg  <= ST_IDLE;
            hready_reg <= 1'b1;
            hresp_reg  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // Committed-write counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_count_reg <= '0;
    end else if (commit && (wr_count_reg != 16'hFFFF)) begin
      wr_count_reg <= wr_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed tests for ahb_sram_slave (reset, word and
// sub-word access, errors, pipelined burst, reset abort).
// Setting AHB_SLAVE_WAIT_EN builds the DUT with two wait states.
module tb_ahb_sram_slave;

  localparam int WAIT_CFG = 2;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_LOW = WAIT_CFG;
`else
  localparam int EXP_LOW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [15:0] wr_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_wr = 16'd0;

  always #5 clk = ~clk;

  ahb_sram_slave #(
    .ADDRESSWIDTH (32),
    .DATAWIDTH    (32),
    .MEM_DEPTH    (256),
    .MEM_DEPTH_LOG(8),
    .BASE_ADDR    (0),
    .WAIT_CYCLES  (WAIT_CFG)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HTRANS   (HTRANS),
    .HWDATA   (HWDATA),
    .HREADYIN (HREADYIN),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA),
    .wr_count (wr_count)
  );

  // Waits (bounded) for a negedge with HREADY high; low = stall cycles seen.
  task automatic wait_ready(output int low);
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (HREADY === 1'b1) break;
      low++;
      @(posedge clk); #1;
    end
  endtask

  // Single NONSEQ transfer; returns data/response from the final data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic [1:0] resp, output int low);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    wait_ready(low);
    rdata = HRDATA;
    resp  = HRESP;
    @(posedge clk); #1;
    $display("xfer %s addr=%h size=%0d wdata=%h -> rdata=%h resp=%0d stall=%0d",
             wr ? "WR" : "RD", addr, size, wdata, rdata, resp, low);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b010;
    HBURST = 3'b000; HPROT = 4'b0011; HTRANS = 2'b00; HWDATA = '0; HREADYIN = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (HREADY !== 1'b1) begin bad++; $display("FAIL reset_hready cyc=%0d got=%b exp=1", i, HREADY); end
      total++; if (HRESP !== 2'b00) begin bad++; $display("FAIL reset_hresp cyc=%0d got=%b exp=00", i, HRESP); end
      total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL reset_hrdata cyc=%0d got=%h exp=0", i, HRDATA); end
      total++; if (wr_count !== 16'h0) begin bad++; $display("FAIL reset_wr_count cyc=%0d got=%0d exp=0", i, wr_count); end
    end
    @(posedge clk); #1;
    $display("reset idle window checked");
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; logic [1:0] resp; int low;
    xfer(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, resp, low);
    exp_wr++;
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL word_wr_resp got=%b exp=00", resp); end
    total++; if (low !== EXP_LOW) begin bad++; $display("FAIL word_wr_stall got=%0d exp=%0d", low, EXP_LOW); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL word_wr_hrdata got=%h exp=0", rd); end
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, resp, low);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd_data got=%h exp=deadbeef", rd); end
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL word_rd_resp got=%b exp=00", resp); end
    total++; if (low !== EXP_LOW) begin bad++; $display("FAIL word_rd_stall got=%0d exp=%0d", low, EXP_LOW); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL word_wr_count got=%0d exp=%0d", wr_count, exp_wr); end
  endtask

  task automatic test_subword();
    logic [31:0] addr_t [4] = '{32'h10, 32'h13, 32'h10, 32'h11};
    logic [2:0]  size_t [4] = '{3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] data_t [4] = '{32'h11223344, 32'hA5EEEEEE, 32'hEEEEBEEF, 32'hEEEE77EE};
    logic [31:0] chk_t  [4] = '{32'h11223344, 32'hA5223344, 32'hA522BEEF, 32'hA52277EF};
    logic [31:0] rd; logic [1:0] resp; int low;
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, addr_t[i], size_t[i], data_t[i], rd, resp, low);
      exp_wr++;
      xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, resp, low);
      total++; if (rd !== chk_t[i]) begin bad++; $display("FAIL subword_%0d got=%h exp=%h", i, rd, chk_t[i]); end
    end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL subword_wr_count got=%0d exp=%0d", wr_count, exp_wr); end
  endtask

  task automatic test_errors();
    logic [31:0] addr_t [5] = '{32'h400, 32'h12, 32'h11, 32'h10, 32'h400};
    logic [2:0]  size_t [5] = '{3'b010, 3'b010, 3'b001, 3'b011, 3'b010};
    logic        wr_t   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rd; logic [1:0] resp; int low;
    // Cycle-exact view of the two-cycle error response.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h402; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
    @(negedge clk);
    total++; if (HREADY !== 1'b0) begin bad++; $display("FAIL err1_hready got=%b exp=0", HREADY); end
    total++; if (HRESP !== 2'b01) begin bad++; $display("FAIL err1_hresp got=%b exp=01", HRESP); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (HREADY !== 1'b1) begin bad++; $display("FAIL err2_hready got=%b exp=1", HREADY); end
    total++; if (HRESP !== 2'b01) begin bad++; $display("FAIL err2_hresp got=%b exp=01", HRESP); end
    total++; if (HRDATA !== 32'h0) begin bad++; $display("FAIL err2_hrdata got=%h exp=0", HRDATA); end
    @(posedge clk); #1;
    $display("xfer WR addr=00000402 size=2 -> two-cycle error response");
    for (int i = 0; i < 5; i++) begin
      xfer(wr_t[i], addr_t[i], size_t[i], 32'hFFFFFFFF, rd, resp, low);
      total++; if (resp !== 2'b01) begin bad++; $display("FAIL err_resp_%0d got=%b exp=01", i, resp); end
      total++; if (low !== 1) begin bad++; $display("FAIL err_stall_%0d got=%0d exp=1", i, low); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_hrdata_%0d got=%h exp=0", i, rd); end
    end
    // HREADYIN low: the address phase must be ignored.
    HREADYIN = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge clk); #1;
    HREADYIN = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BAD0BAD;
    @(negedge clk);
    total++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin bad++; $display("FAIL hreadyin_ignored got=%b/%b exp=1/00", HREADY, HRESP); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h10, 3'b010, 32'h0, rd, resp, low);
    total++; if (rd !== 32'hA52277EF) begin bad++; $display("FAIL err_mem_kept got=%h exp=a52277ef", rd); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL err_wr_count got=%0d exp=%0d", wr_count, exp_wr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] resp; int low; int low2;
    int nb = 1; int done = 0; int addr_beat = 0;
    logic addr_xfer = 1'b1; logic data_active = 1'b0; logic busy_done = 1'b0; logic rdy;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'b010; HBURST = 3'b101;
    for (int cyc = 0; cyc < 80 && done < 8; cyc++) begin
      @(negedge clk); rdy = HREADY;
      @(posedge clk); #1;
      if (rdy) begin
        if (data_active) done++;
        data_active = addr_xfer;
        if (addr_xfer) HWDATA = 32'h10000000 + 32'(addr_beat);
        if (nb == 4 && !busy_done) begin
          HTRANS = 2'b01; busy_done = 1'b1; addr_xfer = 1'b0;
        end else if (nb < 8) begin
          HTRANS = 2'b11; HADDR = 32'h20 + 32'(4 * nb); addr_beat = nb; nb++; addr_xfer = 1'b1;
        end else begin
          HTRANS = 2'b00; HSEL = 1'b0; addr_xfer = 1'b0;
        end
      end
    end
    HBURST = 3'b000;
    total++; if (done !== 8) begin bad++; $display("FAIL burst_beats got=%0d exp=8", done); end
    exp_wr = exp_wr + 16'd8;
    $display("burst 8 beats written with one BUSY");
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 32'h20 + 32'(4 * i), 3'b010, 32'h0, rd, resp, low);
      total++; if (rd !== 32'h10000000 + 32'(i)) begin bad++; $display("FAIL burst_rd_%0d got=%h exp=%h", i, rd, 32'h10000000 + 32'(i)); end
    end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL burst_wr_count got=%0d exp=%0d", wr_count, exp_wr); end
    // Write immediately followed by a read of the same word.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge clk); #1;
    HWDATA = 32'h55AA55AA; HWRITE = 1'b0;
    wait_ready(low);
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    wait_ready(low2);
    rd = HRDATA;
    @(posedge clk); #1;
    exp_wr++;
    $display("b2b WR then RD addr=00000040 -> rdata=%h", rd);
    total++; if (rd !== 32'h55AA55AA) begin bad++; $display("FAIL b2b_rd got=%h exp=55aa55aa", rd); end
    total++; if (low !== EXP_LOW || low2 !== EXP_LOW) begin bad++; $display("FAIL b2b_stall got=%0d/%0d exp=%0d", low, low2, EXP_LOW); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL b2b_wr_count got=%0d exp=%0d", wr_count, exp_wr); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic [1:0] resp; int low;
    xfer(1'b1, 32'h44, 3'b010, 32'h12345678, rd, resp, low);
    exp_wr++;
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL abort_pre_count got=%0d exp=%0d", wr_count, exp_wr); end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h44; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge clk); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h99999999; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_wr = 16'd0;
    @(negedge clk);
    total++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin bad++; $display("FAIL abort_ready got=%b/%b exp=1/00", HREADY, HRESP); end
    total++; if (wr_count !== 16'h0) begin bad++; $display("FAIL abort_count got=%0d exp=0", wr_count); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h44, 3'b010, 32'h0, rd, resp, low);
    total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL abort_mem got=%h exp=12345678", rd); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL abort_post_count got=%0d exp=%0d", wr_count, exp_wr); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
